// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants and types for the line-clear engine.
package tetris_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } clr_state_t;

    typedef logic [BOARD_COLS-1:0] row_t;

endpackage

// File: rtl/line_clear_engine_if.sv
// Handshake and board bus between the line-clear engine and its client.
interface line_clear_engine_if #(
    parameter int COLS    = tetris_pkg::BOARD_COLS,
    parameter int ROWS    = tetris_pkg::BOARD_ROWS,
    parameter int TOTAL_W = 16
);
    logic                      start;
    logic                      pause;
    logic [ROWS*COLS-1:0]      board_in;
    logic [ROWS*COLS-1:0]      board_out;
    logic                      busy;
    logic                      done;
    logic [$clog2(ROWS+1)-1:0] lines_cleared;
    logic [TOTAL_W-1:0]        total_lines;

    modport master (
        output start, pause, board_in,
        input  board_out, busy, done, lines_cleared, total_lines
    );

    modport slave (
        input  start, pause, board_in,
        output board_out, busy, done, lines_cleared, total_lines
    );
endinterface

// File: rtl/board_row_shift.sv
// Removes one row from the board: rows above it drop by one, a zero row enters at the top.
module board_row_shift #(
    parameter int COLS  = tetris_pkg::BOARD_COLS,
    parameter int ROWS  = tetris_pkg::BOARD_ROWS,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] board,
    input  logic [ROW_W-1:0]     row,
    output logic [ROWS*COLS-1:0] shifted
);

    // Per-row select: keep below the removed row, pull from above at or above it.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r < int'(row)) begin
                shifted[r*COLS +: COLS] = board[r*COLS +: COLS];
            end else if (r < ROWS - 1) begin
                shifted[r*COLS +: COLS] = board[(r+1)*COLS +: COLS];
            end else begin
                shifted[r*COLS +: COLS] = '0;
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Bottom-up row-clear engine: snapshots the board on start, removes every full row,
// and reports per-pass and saturating running line counts.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int COLS    = BOARD_COLS,
    parameter int ROWS    = BOARD_ROWS,
    parameter int TOTAL_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    line_clear_engine_if.slave  bus
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int N     = ROWS * COLS;

    clr_state_t         state_r, state_n_s;
    logic [ROW_W-1:0]   row_r, row_n_s;
    logic [CNT_W-1:0]   count_r, count_n_s;
    logic [N-1:0]       board_r, board_n_s, shifted_s;
    logic               busy_r, busy_n_s;
    logic               done_r, done_n_s;
    logic [CNT_W-1:0]   lines_r, lines_n_s;
    logic [TOTAL_W-1:0] total_r, total_n_s;
    logic [TOTAL_W:0]   total_sum_s;
    logic               full_s;

    board_row_shift #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W)) u_shift (
        .board   (board_r),
        .row     (row_r),
        .shifted (shifted_s)
    );

    assign full_s      = &board_r[row_r*COLS +: COLS];
    assign total_sum_s = (TOTAL_W+1)'(total_r) + (TOTAL_W+1)'(count_r);

    // Next-state and next-output logic; pause holds everything at its current value.
    always_comb begin
        state_n_s = state_r;
        row_n_s   = row_r;
        count_n_s = count_r;
        board_n_s = board_r;
        lines_n_s = lines_r;
        total_n_s = total_r;
        if (!bus.pause) begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        board_n_s = bus.board_in;
                        row_n_s   = ROW_W'(0);
                        count_n_s = CNT_W'(0);
                        state_n_s = SCAN;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                SCAN: begin
                    if (full_s) begin
                        // Row index stays put so the row dropped into place is re-checked.
                        board_n_s = shifted_s;
                        count_n_s = count_r + CNT_W'(1);
                    end else if (row_r == ROW_W'(ROWS - 1)) begin
                        state_n_s = DONE;
                        lines_n_s = count_r;
                        total_n_s = total_sum_s[TOTAL_W] ? {TOTAL_W{1'b1}}
                                                         : total_sum_s[TOTAL_W-1:0];
                    end else begin
                        row_n_s = row_r + ROW_W'(1);
                    end
                end
                DONE: begin
                    state_n_s = IDLE;
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
        busy_n_s = (state_n_s != IDLE);
        done_n_s = (state_n_s == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            row_r   <= '0;
            count_r <= '0;
            board_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            lines_r <= '0;
            total_r <= '0;
        end else begin
            state_r <= state_n_s;
            row_r   <= row_n_s;
            count_r <= count_n_s;
            board_r <= board_n_s;
            busy_r  <= busy_n_s;
            done_r  <= done_n_s;
            lines_r <= lines_n_s;
            total_r <= total_n_s;
        end
    end

    assign bus.board_out     = board_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.lines_cleared = lines_r;
    assign bus.total_lines   = total_r;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed self-checking bench for line_clear_engine at COLS=10, ROWS=22.
module tb_line_clear_engine;

    localparam int COLS    = 10;
    localparam int ROWS    = 22;
    localparam int TOTAL_W = 16;
    localparam int N       = COLS * ROWS;
    localparam int LIMIT   = 200;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    line_clear_engine_if #(.COLS(COLS), .ROWS(ROWS), .TOTAL_W(TOTAL_W)) bus ();

    line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .TOTAL_W(TOTAL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] set_row(input logic [N-1:0] b, input int r,
                                             input logic [COLS-1:0] v);
        logic [N-1:0] t;
        t = b;
        t[r*COLS +: COLS] = v;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives a one-cycle start with the given board; cyc becomes 1 in the first SCAN cycle.
    task automatic launch(input logic [N-1:0] b);
        bus.board_in = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc       = 1;
    endtask

    task automatic wait_done(input string name);
        while (bus.done !== 1'b1 && cyc < LIMIT) step();
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, LIMIT);
        end
    endtask

    task automatic check_pass(input string name, input int exp_cyc, input int exp_lines,
                              input int exp_total, input logic [N-1:0] exp_board);
        wait_done(name);
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s done_cycle got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (bus.lines_cleared !== 5'(exp_lines)) begin
            errors++;
            $display("FAIL %s lines_cleared got %0d expected %0d", name, bus.lines_cleared, exp_lines);
        end
        checks++;
        if (bus.total_lines !== 16'(exp_total)) begin
            errors++;
            $display("FAIL %s total_lines got %0d expected %0d", name, bus.total_lines, exp_total);
        end
        checks++;
        if (bus.board_out !== exp_board) begin
            errors++;
            $display("FAIL %s board_out got %h expected %h", name, bus.board_out, exp_board);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.board_out !== exp_board) begin
            errors++;
            $display("FAIL %s after_done done=%b busy=%b expected 0 0 with board held",
                     name, bus.done, bus.busy);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.board_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.board_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.lines_cleared !== 5'd0 || bus.total_lines !== 16'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b lines=%0d total=%0d expected all zero",
                     bus.busy, bus.done, bus.lines_cleared, bus.total_lines);
        end
    endtask

    task automatic test_empty();
        launch('0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL empty busy_after_start got %b expected 1", bus.busy);
        end
        check_pass("empty", 23, 0, 0, '0);
    endtask

    task automatic test_two_bottom();
        logic [N-1:0] b;
        logic [N-1:0] e;
        b = '0;
        b = set_row(b, 0, 10'h3FF);
        b = set_row(b, 1, 10'h3FF);
        b = set_row(b, 2, 10'h001);
        e = set_row('0, 0, 10'h001);
        launch(b);
        check_pass("two_bottom", 25, 2, 2, e);
    endtask

    task automatic test_split();
        logic [N-1:0] b;
        logic [N-1:0] e;
        b = '0;
        b = set_row(b, 3, 10'h3FF);
        b = set_row(b, 4, 10'h155);
        b = set_row(b, 5, 10'h3FF);
        b = set_row(b, 6, 10'h2AA);
        e = '0;
        e = set_row(e, 3, 10'h155);
        e = set_row(e, 4, 10'h2AA);
        launch(b);
        check_pass("split", 25, 2, 4, e);
    endtask

    task automatic test_all_full();
        logic [N-1:0] b;
        b = '1;
        do_reset();
        launch(b);
        check_pass("all_full_1", 45, 22, 22, '0);
        launch(b);
        check_pass("all_full_2", 45, 22, 44, '0);
    endtask

    task automatic test_pause();
        logic [N-1:0] b;
        logic [N-1:0] held;
        int extra;
        b = set_row('0, 0, 10'h3FF);
        launch(b);
        while (cyc < 3) step();
        bus.pause = 1'b1;
        held      = bus.board_out;
        while (cyc < 8) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.board_out !== held || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold busy=%b done=%b expected 1 0 with board frozen",
                     bus.busy, bus.done);
        end
        bus.pause = 1'b0;
        while (cyc < 12) step();
        bus.start    = 1'b1;
        bus.board_in = '1;
        step();
        bus.start = 1'b0;
        // Five paused edges push the unpaused 24-cycle pass out to cycle 29.
        check_pass("pause", 29, 1, 45, '0);
        extra = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL pause_no_second_done got %0d extra done pulses expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] b;
        int seen;
        b = '0;
        for (int r = 0; r < 4; r++) b = set_row(b, r, 10'h3FF);
        b = set_row(b, 4, 10'h0F0);
        launch(b);
        while (cyc < 10) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.board_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.lines_cleared !== 5'd0 || bus.total_lines !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid outputs busy=%b done=%b lines=%0d total=%0d expected all zero",
                     bus.busy, bus.done, bus.lines_cleared, bus.total_lines);
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d done pulses expected 0", seen);
        end
        launch(b);
        check_pass("after_reset", 27, 4, 4, set_row('0, 0, 10'h0F0));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.board_in = '0;
        test_reset();
        test_empty();
        test_two_bottom();
        test_split();
        test_all_full();
        test_pause();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
